up_down_counter_with_clk_divider_core: RTL and testbench

UP_DOWN_COUNTER_WITH_CLK_DIVIDER_CORE -- requirements
Module: up_down_counter_with_clk_divider

---
 rtl/up_down_counter_with_clk_divider_core.sv | 59 +++++
 tb/tb_up_down_counter_with_clk_divider_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_with_clk_divider_core.sv
// Up/down counter pair advanced by a clock-enable divider tick.
// Define UDC_DIV_BYPASS_EN to remove the divider (tick on every enabled edge).
module up_down_counter_with_clk_divider_core #(
  parameter int WIDTH     = 4,
  parameter int DIV_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             enable,
  output logic [WIDTH-1:0] count_up,
  output logic [WIDTH-1:0] count_down
);

  logic             w_tick;
  logic [WIDTH-1:0] r_count_up;
  logic [WIDTH-1:0] r_count_down;

`ifdef UDC_DIV_BYPASS_EN
  assign w_tick = enable;
`else
  localparam int DW =
    (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(DIV_RATIO - 1);

  logic [DW-1:0] r_div_cnt;

  assign w_tick = enable &&
    (r_div_cnt == DIV_LAST);

  // Phase freezes while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (enable) begin
      r_div_cnt <= w_tick ? '0
        : r_div_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count_up   <= '0;
      r_count_down <= '1;
    end else if (w_tick) begin
      if (sel) begin
        r_count_down <= r_count_down - 1'b1;
      end else begin
        r_count_up <= r_count_up + 1'b1;
      end
    end
  end

  assign count_up   = r_count_up;
  assign count_down = r_count_down;

endmodule

// File: tb/tb_up_down_counter_with_clk_divider_core.sv
// Directed bench for the divided up/down counter.
// Default build: WIDTH=4, DIV_RATIO=2, divider active.
module tb_up_down_counter_with_clk_divider_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] count_up;
  logic [3:0] count_down;

  int n_cmp = 0;
  int n_err = 0;

  up_down_counter_with_clk_divider_core #(
    .WIDTH(4),
    .DIV_RATIO(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .enable(enable),
    .count_up(count_up),
    .count_down(count_down)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (count_up !== 4'd0) begin
      n_err++;
      $display("FAIL reset_up got %0d want 0",
        count_up);
    end
    n_cmp++;
    if (count_down !== 4'd15) begin
      n_err++;
      $display("FAIL reset_dn got %0d want 15",
        count_down);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_startup();
    logic [3:0] exp_up [4];
    exp_up[0] = 4'd0;
    exp_up[1] = 4'd1;
    exp_up[2] = 4'd1;
    exp_up[3] = 4'd2;
    do_reset();
    enable = 1'b1;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      n_cmp++;
      if (count_up !== exp_up[i]) begin
        n_err++;
        $display("FAIL start_up%0d got %0d want %0d",
          i + 1, count_up, exp_up[i]);
      end
    end
    n_cmp++;
    if (count_down !== 4'd15) begin
      n_err++;
      $display("FAIL start_dn got %0d want 15",
        count_down);
    end
    sel = 1'b1;
    step(1);
    n_cmp++;
    if (count_down !== 4'd15) begin
      n_err++;
      $display("FAIL down_e1 got %0d want 15",
        count_down);
    end
    step(1);
    n_cmp++;
    if (count_down !== 4'd14) begin
      n_err++;
      $display("FAIL down_e2 got %0d want 14",
        count_down);
    end
    n_cmp++;
    if (count_up !== 4'd2) begin
      n_err++;
      $display("FAIL down_hold_up got %0d want 2",
        count_up);
    end
  endtask

  task automatic test_wrap_up();
    do_reset();
    enable = 1'b1;
    sel = 1'b0;
    step(30);
    n_cmp++;
    if (count_up !== 4'd15) begin
      n_err++;
      $display("FAIL wrap_up30 got %0d want 15",
        count_up);
    end
    step(2);
    n_cmp++;
    if (count_up !== 4'd0) begin
      n_err++;
      $display("FAIL wrap_up32 got %0d want 0",
        count_up);
    end
  endtask

  task automatic test_wrap_down();
    do_reset();
    enable = 1'b1;
    sel = 1'b1;
    step(2);
    n_cmp++;
    if (count_down !== 4'd14) begin
      n_err++;
      $display("FAIL wrap_dn2 got %0d want 14",
        count_down);
    end
    step(28);
    n_cmp++;
    if (count_down !== 4'd0) begin
      n_err++;
      $display("FAIL wrap_dn30 got %0d want 0",
        count_down);
    end
    step(2);
    n_cmp++;
    if (count_down !== 4'd15) begin
      n_err++;
      $display("FAIL wrap_dn32 got %0d want 15",
        count_down);
    end
    step(2);
    n_cmp++;
    if (count_down !== 4'd14) begin
      n_err++;
      $display("FAIL wrap_dn34 got %0d want 14",
        count_down);
    end
    n_cmp++;
    if (count_up !== 4'd0) begin
      n_err++;
      $display("FAIL wrap_dn_up got %0d want 0",
        count_up);
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    enable = 1'b1;
    sel = 1'b0;
    step(1);
    enable = 1'b0;
    step(50);
    n_cmp++;
    if (count_up !== 4'd0 || count_down !== 4'd15) begin
      n_err++;
      $display("FAIL gate_hold got %0d/%0d want 0/15",
        count_up, count_down);
    end
    enable = 1'b1;
    step(1);
    n_cmp++;
    if (count_up !== 4'd1) begin
      n_err++;
      $display("FAIL gate_resume got %0d want 1",
        count_up);
    end
  endtask

  task automatic test_sel_sampling();
    do_reset();
    enable = 1'b1;
    sel = 1'b1;
    step(1);
    sel = 1'b0;
    step(1);
    n_cmp++;
    if (count_up !== 4'd1 || count_down !== 4'd15) begin
      n_err++;
      $display("FAIL sel_samp got %0d/%0d want 1/15",
        count_up, count_down);
    end
  endtask

  task automatic test_reset_mid_period();
    do_reset();
    enable = 1'b1;
    sel = 1'b0;
    step(1);
    do_reset();
    enable = 1'b1;
    step(1);
    n_cmp++;
    if (count_up !== 4'd0) begin
      n_err++;
      $display("FAIL midrst_e1 got %0d want 0",
        count_up);
    end
    step(1);
    n_cmp++;
    if (count_up !== 4'd1) begin
      n_err++;
      $display("FAIL midrst_e2 got %0d want 1",
        count_up);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    sel = 1'b0;
    step(10);
    n_cmp++;
    if (count_up !== 4'd5) begin
      n_err++;
      $display("FAIL async_pre got %0d want 5",
        count_up);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (count_up !== 4'd0 || count_down !== 4'd15) begin
      n_err++;
      $display("FAIL async_rst got %0d/%0d want 0/15",
        count_up, count_down);
    end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_wrap_up();
    test_wrap_down();
    test_enable_gating();
    test_sel_sampling();
    test_reset_mid_period();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
